// File: rtl/run_result_checker_if.sv
// Bus bundle for run_result_checker: start/halt inputs, debug read port,
// expected-value ROM port and the result outputs.
// master = the checker, slave = the harness (CPU debug port, ROM, host).
`timescale 1ns/1ps

interface run_result_checker_if #(
    parameter int DW        = 32,
    parameter int NREG      = 32,
    parameter int MEM_WORDS = 128,
    parameter int FCW       = 8
);
    localparam int IW = $clog2(NREG + MEM_WORDS);

    logic          start;
    logic [31:0]   iaddr;
    logic          cpu_rst;
    logic          dbg_ren;
    logic          dbg_sel;
    logic [IW-1:0] dbg_addr;
    logic [DW-1:0] dbg_rdata;
    logic [IW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          done;
    logic          pass;
    logic [FCW-1:0] fail_cnt;
    logic [IW-1:0] first_fail_idx;
    logic [DW-1:0] first_fail_got;
    logic [DW-1:0] first_fail_exp;

    modport master (
        input  start, iaddr, dbg_rdata, exp_data,
        output cpu_rst, dbg_ren, dbg_sel, dbg_addr, exp_addr,
               done, pass, fail_cnt, first_fail_idx, first_fail_got, first_fail_exp
    );

    modport slave (
        output start, iaddr, dbg_rdata, exp_data,
        input  cpu_rst, dbg_ren, dbg_sel, dbg_addr, exp_addr,
               done, pass, fail_cnt, first_fail_idx, first_fail_got, first_fail_exp
    );
endinterface

// File: rtl/run_result_checker.sv
// run_result_checker: holds the CPU in reset, runs it for a bounded number of
// cycles, freezes it, then walks register file and data memory through the
// debug port comparing every word against an expected-value ROM.
// Optional feature: define CHECKER_EARLY_HALT_EN to leave RUN early once the
// instruction address has been stable for HALT_WIN consecutive cycles.
//
// state   | meaning
// IDLE    | after reset, CPU held in reset, waiting for start
// HOLD    | CPU reset held for RST_CYCLES cycles
// RUN     | CPU running, cycle budget counting down
// CHECK   | CPU frozen, one debug read issued per cycle, compare one cycle later
// DONE    | results valid and held until start or reset
`timescale 1ns/1ps

module run_result_checker #(
    parameter int DW         = 32,
    parameter int NREG       = 32,
    parameter int MEM_WORDS  = 128,
    parameter int RST_CYCLES = 10,
    parameter int MAX_CYCLES = 1000,
    parameter int HALT_WIN   = 4,
    parameter int FCW        = 8
) (
    input  logic clk,
    input  logic reset,
    run_result_checker_if.master bus
);
    localparam int NCHK = NREG + MEM_WORDS;
    localparam int IW   = $clog2(NCHK);
    localparam int HCW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int RCW  = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state;
    logic [HCW-1:0] hold_cnt;
    logic [RCW-1:0] run_cnt;
    logic [IW-1:0]  iss_idx;
    logic           cmp_vld;
    logic [IW-1:0]  cmp_idx;

    logic           mismatch;
    logic [FCW-1:0] fail_next;
    logic           iss_last;
    logic [IW-1:0]  iss_next;
    logic           nxt_sel;
    logic [IW-1:0]  nxt_addr;
    logic           cmp_last;
    logic           halt_hit;

    // Compare result, saturating fail count and next debug read address
    always_comb begin
        mismatch  = cmp_vld && (bus.dbg_rdata != bus.exp_data);
        fail_next = bus.fail_cnt;
        if (mismatch && !(&bus.fail_cnt))
            fail_next = bus.fail_cnt + 1'b1;
        iss_last  = (iss_idx == IW'(NCHK - 1));
        iss_next  = iss_idx + 1'b1;
        nxt_sel   = (iss_next >= IW'(NREG));
        nxt_addr  = nxt_sel ? (iss_next - IW'(NREG)) : iss_next;
        cmp_last  = cmp_vld && (cmp_idx == IW'(NCHK - 1));
    end

`ifdef CHECKER_EARLY_HALT_EN
    localparam int SCW = $clog2(HALT_WIN + 1);
    logic [SCW-1:0] stab_cnt;
    logic [SCW-1:0] stab_next;
    logic [31:0]    prev_iaddr;

    // Length of the current run of identical instruction addresses in RUN
    always_comb begin
        stab_next = SCW'(1);
        if (stab_cnt != '0 && bus.iaddr == prev_iaddr)
            stab_next = (stab_cnt == SCW'(HALT_WIN)) ? stab_cnt : stab_cnt + 1'b1;
        halt_hit = (stab_next == SCW'(HALT_WIN));
    end
`else
    localparam logic [31:0] HALT_WIN_L = HALT_WIN;
    logic unused_iaddr;
    assign unused_iaddr = ^{bus.iaddr, HALT_WIN_L};
    assign halt_hit     = 1'b0;
`endif

    // Sequencer: reset/run/freeze control, check walk and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            hold_cnt           <= '0;
            run_cnt            <= '0;
            iss_idx            <= '0;
            cmp_vld            <= 1'b0;
            cmp_idx            <= '0;
            bus.cpu_rst        <= 1'b1;
            bus.dbg_ren        <= 1'b0;
            bus.dbg_sel        <= 1'b0;
            bus.dbg_addr       <= '0;
            bus.exp_addr       <= '0;
            bus.done           <= 1'b0;
            bus.pass           <= 1'b0;
            bus.fail_cnt       <= '0;
            bus.first_fail_idx <= '0;
            bus.first_fail_got <= '0;
            bus.first_fail_exp <= '0;
`ifdef CHECKER_EARLY_HALT_EN
            stab_cnt           <= '0;
            prev_iaddr         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state              <= S_HOLD;
                        hold_cnt           <= HCW'(RST_CYCLES - 1);
                        bus.cpu_rst        <= 1'b1;
                        bus.done           <= 1'b0;
                        bus.pass           <= 1'b0;
                        bus.fail_cnt       <= '0;
                        bus.first_fail_idx <= '0;
                        bus.first_fail_got <= '0;
                        bus.first_fail_exp <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        state       <= S_RUN;
                        bus.cpu_rst <= 1'b0;
                        run_cnt     <= RCW'(MAX_CYCLES - 1);
`ifdef CHECKER_EARLY_HALT_EN
                        stab_cnt    <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_RUN: begin
`ifdef CHECKER_EARLY_HALT_EN
                    stab_cnt   <= stab_next;
                    prev_iaddr <= bus.iaddr;
`endif
                    if (run_cnt == '0 || halt_hit) begin
                        // Freeze the CPU and present index 0 on the debug/ROM ports
                        state        <= S_CHECK;
                        bus.cpu_rst  <= 1'b1;
                        bus.dbg_ren  <= 1'b1;
                        bus.dbg_sel  <= 1'b0;
                        bus.dbg_addr <= '0;
                        bus.exp_addr <= '0;
                        iss_idx      <= '0;
                        cmp_vld      <= 1'b0;
                    end else begin
                        run_cnt <= run_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    cmp_vld      <= bus.dbg_ren;
                    cmp_idx      <= iss_idx;
                    bus.fail_cnt <= fail_next;
                    if (mismatch && bus.fail_cnt == '0) begin
                        bus.first_fail_idx <= cmp_idx;
                        bus.first_fail_got <= bus.dbg_rdata;
                        bus.first_fail_exp <= bus.exp_data;
                    end
                    if (bus.dbg_ren) begin
                        if (iss_last) begin
                            bus.dbg_ren  <= 1'b0;
                            bus.dbg_sel  <= 1'b0;
                            bus.dbg_addr <= '0;
                            bus.exp_addr <= '0;
                        end else begin
                            iss_idx      <= iss_next;
                            bus.dbg_sel  <= nxt_sel;
                            bus.dbg_addr <= nxt_addr;
                            bus.exp_addr <= iss_next;
                        end
                    end
                    if (cmp_last) begin
                        state    <= S_DONE;
                        cmp_vld  <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (fail_next == '0);
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    bus.cpu_rst <= 1'b1;
                    bus.dbg_ren <= 1'b0;
                end
            endcase
        end
    end
endmodule
